// File: rtl/rlc_meas_pkg.sv
// rlc_meas_pkg: shared types and default widths for RLC measurement monitors
// Contents: meas_state_t FSM encoding and default fixed-point / counter widths.
package rlc_meas_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LO,
        WAIT_HI,
        SETTLE
    } meas_state_t;

    localparam int DEF_WIDTH = 25;
    localparam int DEF_EXP   = -16;
    localparam int DEF_CNT_W = 20;

endpackage

// File: rtl/abs_diff_cmp.sv
// abs_diff_cmp: combinational |a - b| <= band check on signed fixed-point values
// Ports: a, b, band (signed WIDTH, same exponent); in_band high when the distance is within band.
module abs_diff_cmp
    import rlc_meas_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic signed [WIDTH-1:0] band,
    output logic                    in_band
);

    // One extra bit holds any difference and its magnitude without overflow.
    logic signed [WIDTH:0] diff;
    logic signed [WIDTH:0] mag;

    always_comb begin
        diff    = (WIDTH+1)'(a) - (WIDTH+1)'(b);
        mag     = (diff < 0) ? -diff : diff;
        in_band = mag <= (WIDTH+1)'(band);
    end

endmodule

// File: rtl/rlc_step_monitor.sv
// rlc_step_monitor: step-response metrics (rise time, peak, settling time) on the RLC v_out stream
// Ports: clk, rst (synchronous, active-low); start pulse latches lo_thresh/hi_thresh/v_final/band;
//        v_out sample each clk; busy, done (1-cycle pulse), timeout (sticky until next start);
//        rise_cycles, settle_cycles, peak results held until the next start.
module rlc_step_monitor
    import rlc_meas_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int EXP         = DEF_EXP,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SETTLE_HOLD = 16,
    parameter int MAX_CYCLES  = 2**20 - 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] v_out,
    input  logic signed [WIDTH-1:0] lo_thresh,
    input  logic signed [WIDTH-1:0] hi_thresh,
    input  logic signed [WIDTH-1:0] v_final,
    input  logic signed [WIDTH-1:0] band,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout,
    output logic [CNT_W-1:0]        rise_cycles,
    output logic [CNT_W-1:0]        settle_cycles,
    output logic signed [WIDTH-1:0] peak
);

    localparam int RUN_W = $clog2(SETTLE_HOLD + 1);

    // All inputs share one exponent; nothing here rescales, so only its sign is sanity-checked.
    if (SETTLE_HOLD < 1 || EXP > 0) begin : g_param_chk
        $error("rlc_step_monitor: SETTLE_HOLD must be >= 1 and EXP <= 0");
    end

    meas_state_t             state, state_n;
    logic [CNT_W-1:0]        cyc, cyc_n, t_lo, t_lo_n, rise_n, settle_n;
    logic [RUN_W-1:0]        run, run_n;
    logic signed [WIDTH-1:0] lo_q, lo_n, hi_q, hi_n, vf_q, vf_n, band_q, band_n, peak_n;
    logic                    timeout_n, done_n, in_band, ge_lo, ge_hi;

    abs_diff_cmp #(.WIDTH(WIDTH)) u_band (
        .a       (v_out),
        .b       (vf_q),
        .band    (band_q),
        .in_band (in_band)
    );

    assign ge_lo = v_out >= lo_q;
    assign ge_hi = v_out >= hi_q;
    assign busy  = state != IDLE;

    always_comb begin
        state_n   = state;
        cyc_n     = cyc;
        t_lo_n    = t_lo;
        run_n     = run;
        lo_n      = lo_q;
        hi_n      = hi_q;
        vf_n      = vf_q;
        band_n    = band_q;
        peak_n    = peak;
        rise_n    = rise_cycles;
        settle_n  = settle_cycles;
        timeout_n = timeout;
        done_n    = 1'b0;
        if (start) begin
            state_n   = WAIT_LO;
            cyc_n     = '0;
            run_n     = '0;
            lo_n      = lo_thresh;
            hi_n      = hi_thresh;
            vf_n      = v_final;
            band_n    = band;
            peak_n    = v_out;
            timeout_n = 1'b0;
        end else if (state != IDLE) begin
            cyc_n  = cyc + 1'b1;
            peak_n = (v_out > peak) ? v_out : peak;
            if (state == WAIT_LO && ge_lo) begin
                t_lo_n  = cyc;
                state_n = WAIT_HI;
            end
            // A hi crossing straight from WAIT_LO yields t_lo == cyc, hence rise 0.
            if (state != SETTLE && ge_hi) begin
                rise_n  = cyc - t_lo_n;
                state_n = SETTLE;
            end
            // The sample that crosses hi is already judged for settling.
            if (state_n == SETTLE) begin
                if (in_band && run == '0)
                    settle_n = cyc;
                run_n = in_band ? run + 1'b1 : '0;
            end
            if (run_n == RUN_W'(SETTLE_HOLD)) begin
                done_n  = 1'b1;
                state_n = IDLE;
            end else if (cyc == CNT_W'(MAX_CYCLES)) begin
                timeout_n = 1'b1;
                done_n    = 1'b1;
                state_n   = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cyc           <= '0;
            t_lo          <= '0;
            run           <= '0;
            lo_q          <= '0;
            hi_q          <= '0;
            vf_q          <= '0;
            band_q        <= '0;
            peak          <= '0;
            rise_cycles   <= '0;
            settle_cycles <= '0;
            timeout       <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_n;
            cyc           <= cyc_n;
            t_lo          <= t_lo_n;
            run           <= run_n;
            lo_q          <= lo_n;
            hi_q          <= hi_n;
            vf_q          <= vf_n;
            band_q        <= band_n;
            peak          <= peak_n;
            rise_cycles   <= rise_n;
            settle_cycles <= settle_n;
            timeout       <= timeout_n;
            done          <= done_n;
        end
    end

endmodule
